mem_bus_master: RTL and testbench

Initiator side of the main-memory port: accepts single-word or short-burst read/write requests from the core datapath and drives the memory's `address`/`data_in`/`rd`/`wr` strobes. It captures the memory's registered `data_out` and returns it as a read-data stream. The block sits between the control unit and main memory and is the only agent that drives the memory strobes.

---
 rtl/mem_bus_master_if.sv | 51 +++++
 rtl/mem_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// Purpose : Bundles the request, write-beat, read-beat and memory-strobe
//           signals of the main-memory initiator port.
// Params  : BURST_MAX_LOG2 - width of the req_len field.
// Modports: master - the mem_bus_master block itself.
//           slave  - the core datapath plus main memory on the other side.
interface mem_bus_master_if #(
    parameter int unsigned BURST_MAX_LOG2 = 3
);
    // Request channel from the core datapath
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [31:0]               req_addr;
    logic [BURST_MAX_LOG2-1:0] req_len;

    // Write-beat channel
    logic                      wvalid;
    logic                      wready;
    logic [31:0]               wdata;

    // Read-beat stream and completion pulses
    logic                      rvalid;
    logic [31:0]               rdata;
    logic                      done;
    logic                      err;

    // Main-memory strobes
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [31:0]               mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wvalid, wdata,
        input  mem_rdata,
        output req_ready, wready,
        output rvalid, rdata, done, err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wvalid, wdata,
        output mem_rdata,
        input  req_ready, wready,
        input  rvalid, rdata, done, err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_bus_master.sv
// Purpose : Initiator side of the main-memory port. Accepts single-word or
//           short-burst read/write requests, drives the memory address/data
//           strobes, and returns captured read data as an rvalid/rdata stream.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - mem_bus_master_if.master (request, write beats, read
//                    beats, done/err pulses, memory strobes)
// Options : MEM_ALIGN_CHECK_EN - when defined, a request whose start address
//           is not word aligned is accepted but aborted with a one-cycle err
//           pulse and no memory traffic. When undefined, err is constant 0 and
//           the address is used as given.
module mem_bus_master #(
    parameter int unsigned BURST_MAX_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_master_if.master bus
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = BURST_MAX_LOG2;

    // ST_ERR is only reachable when the alignment check is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_DONE  = 3'd4,
        ST_ERR      = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;          // address of the next beat to issue
    logic [LW-1:0]   cnt_q, cnt_d;            // beats still to issue after the current one
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            mem_rd_q, mem_rd_d;
    logic            mem_wr_q, mem_wr_d;
    logic [1:0]      pipe_q, pipe_d;          // read-valid shift: [0] memory output valid, [1] rvalid
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            misaligned_c;

    // Alignment abort qualifier; constant 0 leaves err permanently low.
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_c = (bus.req_addr[1:0] != 2'b00);
`else
    assign misaligned_c = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        pipe_d      = {pipe_q[0], mem_rd_q};

        // Memory data_out is valid the cycle after it sampled mem_rd.
        if (pipe_q[0]) begin
            rdata_d = bus.mem_rdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cnt_d = bus.req_len;
                    if (misaligned_c) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = ST_WR;
                        addr_d  = bus.req_addr;
                    end else begin
                        state_d    = ST_RD;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.req_addr;
                        addr_d     = bus.req_addr + 32'd4;
                    end
                end
            end

            ST_RD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_DRAIN;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + 32'd4;
                    cnt_d      = cnt_q - LW'(1);
                end
            end

            // The last beat is already in the valid pipe on entry, so done
            // lines up with the final rvalid; hold one more cycle for it.
            ST_RD_DRAIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            // wready is high throughout, so wvalid alone marks an accepted beat.
            ST_WR: begin
                if (bus.wvalid) begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.wdata;
                    addr_d      = addr_q + 32'd4;
                    if (cnt_q == '0) begin
                        state_d = ST_WR_DONE;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end

            ST_WR_DONE: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            pipe_q      <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            pipe_q      <= pipe_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.wready    = (state_q == ST_WR);
    assign bus.rvalid    = pipe_q[1];
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Purpose : Self-checking bench for mem_bus_master. A registered memory model
//           sits on the memory strobes; expected beats, addresses, data and
//           pulse timing come from a word-level reference memory and the
//           protocol's cycle rules.
module tb_mem_bus_master;

    localparam int unsigned BL   = 3;
    localparam int          MAXB = 1 << BL;

    logic clk = 1'b0;
    logic rst_n;

    mem_bus_master_if #(.BURST_MAX_LOG2(BL)) bus ();

    mem_bus_master #(.BURST_MAX_LOG2(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory: word value per full byte address written so far.
    logic [31:0] ref_mem [logic [31:0]];

    // Background contents; 0x800 holds the documented test word.
    function automatic logic [31:0] mem_init_word(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[11:2];
        if (idx == 10'h200) return 32'hC200_2814;
        return ({22'd0, idx} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init_word(a);
    endfunction

    // Registered memory model (4 KB window, stored as delta from background).
    bit [31:0] sim_delta [0:1023];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= sim_delta[bus.mem_addr[11:2]] ^ mem_init_word(bus.mem_addr);
        if (bus.mem_wr) sim_delta[bus.mem_addr[11:2]] <= bus.mem_wdata ^ mem_init_word(bus.mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for req_ready, present one request, return one step after the accept edge.
    task automatic issue_req(input logic wr, input logic [31:0] addr, input int nbeats);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        check_eq("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = BL'(nbeats - 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Cycle c = 1 is the cycle following the accept edge.
    task automatic do_read(input logic [31:0] addr, input int nbeats);
        logic [31:0] exp_data [$];
        logic        exp_rd;
        logic        exp_rv;
        for (int i = 0; i < nbeats; i++) exp_data.push_back(ref_word(addr + 32'(4 * i)));
        issue_req(1'b0, addr, nbeats);
        for (int c = 1; c <= nbeats + 3; c++) begin
            @(negedge clk);
            exp_rd = (c <= nbeats);
            exp_rv = (c >= 3) && (c <= nbeats + 2);
            check_eq("rd_strobe", 32'(bus.mem_rd), 32'(exp_rd));
            if (exp_rd) check_eq("rd_addr", bus.mem_addr, addr + 32'(4 * (c - 1)));
            check_eq("rd_rvalid", 32'(bus.rvalid), 32'(exp_rv));
            if (exp_rv) check_eq("rd_rdata", bus.rdata, exp_data[c - 3]);
            check_eq("rd_done", 32'(bus.done), 32'(c == nbeats + 2));
            check_eq("rd_req_ready", 32'(bus.req_ready), 32'(c == nbeats + 3));
            check_eq("rd_quiet", 32'({bus.err, bus.mem_wr, bus.wready}), 32'd0);
        end
    endtask

    // gap[i] = idle cycles inserted before beat i.
    task automatic do_write(input logic [31:0] addr, input int nbeats,
                            input int gap_beat, input int gap_len, input bit rand_gaps);
        logic [31:0] data [$];
        int          gap [$];
        logic [31:0] obs_a [$];
        logic [31:0] obs_d [$];
        int          beat;
        int          idle;
        int          last_wr;
        int          done_c;
        int          ndone;
        for (int i = 0; i < nbeats; i++) begin
            data.push_back($urandom);
            gap.push_back(rand_gaps ? int'($urandom_range(0, 2)) : ((i == gap_beat) ? gap_len : 0));
        end
        issue_req(1'b1, addr, nbeats);
        beat    = 0;
        idle    = gap[0];
        last_wr = -1;
        done_c  = -1;
        ndone   = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                obs_a.push_back(bus.mem_addr);
                obs_d.push_back(bus.mem_wdata);
                last_wr = c;
            end
            if (bus.done) begin
                ndone++;
                done_c = c;
            end
            check_eq("wr_no_rd_err", 32'({bus.mem_rd, bus.err, bus.rvalid}), 32'd0);
            check_eq("wr_wready", 32'(bus.wready), 32'(beat < nbeats));
            if (done_c > 0 && c == done_c + 1) begin
                check_eq("wr_req_ready", 32'(bus.req_ready), 32'd1);
                break;
            end
            check_eq("wr_req_busy", 32'(bus.req_ready), 32'd0);
            if (beat < nbeats && idle == 0) begin
                bus.wvalid = 1'b1;
                bus.wdata  = data[beat];
                beat++;
                if (beat < nbeats) idle = gap[beat];
            end else begin
                bus.wvalid = 1'b0;
                if (idle > 0) idle--;
            end
        end
        bus.wvalid = 1'b0;
        check_eq("wr_beat_count", 32'(obs_a.size()), 32'(nbeats));
        for (int i = 0; i < nbeats && i < obs_a.size(); i++) begin
            check_eq("wr_addr", obs_a[i], addr + 32'(4 * i));
            check_eq("wr_data", obs_d[i], data[i]);
        end
        check_eq("wr_done_count", 32'(ndone), 32'd1);
        check_eq("wr_done_time", 32'(done_c), 32'(last_wr + 1));
        for (int i = 0; i < nbeats; i++) ref_mem[addr + 32'(4 * i)] = data[i];
    endtask

    // Reset asserted mid-way through an 8-beat read.
    task automatic reset_mid_read();
        issue_req(1'b0, 32'h0000_1000, 8);
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_rd_addr", bus.mem_addr, 32'h0000_1004);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_strobes", 32'({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done, bus.err, bus.wready}), 32'd0);
        check_eq("rst_mid_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_mid_rdata", bus.rdata, 32'd0);
        check_eq("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 32'({bus.mem_rd, bus.rvalid, bus.done}), 32'd0);
            check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
        end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic misaligned_write();
        issue_req(1'b1, 32'h0000_0802, 2);
        bus.wvalid = 1'b1;
        bus.wdata  = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_eq("mis_err", 32'(bus.err), 32'(c == 1));
            check_eq("mis_quiet", 32'({bus.mem_wr, bus.wready, bus.done, bus.mem_rd}), 32'd0);
            check_eq("mis_req_ready", 32'(bus.req_ready), 32'(c >= 2));
        end
        bus.wvalid = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        logic [31:0] a;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        #12;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_strobes", 32'({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done, bus.err, bus.wready}), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_read(32'h0000_0800, 1);
        do_read(32'h0000_0800, 4);
        do_write(32'h0000_0810, 3, 1, 2, 1'b0);
        do_read(32'h0000_0810, 3);
        do_read(32'hFFFF_FFFC, 2);

        for (int t = 0; t < 24; t++) begin
            nb = int'($urandom_range(1, MAXB));
            a  = 32'h400 + 32'(4 * $urandom_range(0, 255 - (MAXB - 1)));
            if ($urandom_range(0, 1) == 1) do_write(a, nb, 0, 0, 1'b1);
            else                           do_read(a, nb);
        end

        reset_mid_read();
        do_read(32'h0000_0404, 2);

`ifdef MEM_ALIGN_CHECK_EN
        misaligned_write();
`else
        do_write(32'h0000_0802, 2, 0, 0, 1'b0);
        do_read(32'h0000_0802, 2);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
